descrambler_23b: RTL



---
 rtl/pkg_128b130b.sv | 52 +++++
 rtl/lfsr23_byte.sv | 26 ++
 rtl/descrambler_23b.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pkg_128b130b.sv
// Shared 128b/130b constants, block-state encoding and the 23-bit LFSR single-step function.
// Used by both scrambler and descrambler so the two ends stay bit-identical.
package pkg_128b130b;

  localparam logic [1:0]  HDR_DATA  = 2'b10;
  localparam logic [1:0]  HDR_OS    = 2'b01;

  localparam logic [7:0]  OS_SKP    = 8'hAA;
  localparam logic [7:0]  OS_EIEOS  = 8'h00;

  localparam int          LFSR_W    = 23;
  localparam int          BLK_BYTES = 16;

  // x^23+x^21+x^16+x^8+x^5+x^2+1, Galois form; the x^0 term is the feedback into bit 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 23'h210124;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 23'h1DBFBC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_OS,
    ST_SKP,
    ST_EIE
  } dsc_state_e;

  function automatic logic [LFSR_W-1:0] lfsr23_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[LFSR_W-1];
    return {s[LFSR_W-2:0], fb} ^ ({LFSR_W{fb}} & LFSR_TAPS);
  endfunction

  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return (hdr == 2'b00) || (hdr == 2'b11);
  endfunction

  // Malformed headers are treated as data so the LFSR keeps tracking the transmitter
  function automatic dsc_state_e classify_blk(input logic [1:0] hdr, input logic [7:0] byte0);
    dsc_state_e st;
    st = ST_DATA;
    if (hdr == HDR_OS) begin
      if (byte0 == OS_SKP) begin
        st = ST_SKP;
      end else if (byte0 == OS_EIEOS) begin
        st = ST_EIE;
      end else begin
        st = ST_OS;
      end
    end
    return st;
  endfunction

endpackage

// File: rtl/lfsr23_byte.sv
// Combinational 8-step advance of the 23-bit lane LFSR plus the keystream byte it emits.
// Keystream bit i is the LFSR MSB before step i, so bit 0 pairs with the first serial bit.
module lfsr23_byte
  import pkg_128b130b::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [7:0]        key_o
);

  logic [LFSR_W-1:0] s;
  logic [7:0]        key;

  always_comb begin
    s   = state_i;
    key = 8'h00;
    for (int i = 0; i < 8; i++) begin
      key[i] = s[LFSR_W-1];
      s      = lfsr23_step(s);
    end
  end

  assign state_o = s;
  assign key_o   = key;

endmodule

// File: rtl/descrambler_23b.sv
// Receive-side 128b/130b descrambler: byte-serial blocks in, descrambled/passed-through bytes out.
// One registered stage; no back-pressure, rx_valid low simply stalls all state.
module descrambler_23b
  import pkg_128b130b::*;
#(
  parameter logic [22:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk_1G,
  input  logic       rst_1G,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_blk_start,
  input  logic [1:0] rx_sync_hdr,
  output logic [7:0] dsc_data,
  output logic       dsc_valid,
  output logic       dsc_blk_start,
  output logic       dsc_os,
  output logic       err_hdr,
  output logic       err_align
);

  dsc_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  logic [7:0]        data_q, data_d;
  logic              vld_q, vld_d;
  logic              bstart_q, bstart_d;
  logic              os_q, os_d;
  logic              eh_q, eh_d;
  logic              ea_q, ea_d;

  logic [LFSR_W-1:0] lfsr_adv;
  logic [7:0]        key;

  dsc_state_e        cur_st;
  logic              take;
  logic              last;

  lfsr23_byte u_lfsr (
    .state_i (lfsr_q),
    .state_o (lfsr_adv),
    .key_o   (key)
  );

  // The LFSR only moves on accepted bytes and never looks at received data
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    data_d   = 8'h00;
    vld_d    = 1'b0;
    bstart_d = 1'b0;
    os_d     = 1'b0;
    eh_d     = 1'b0;
    ea_d     = 1'b0;
    cur_st   = state_q;
    take     = 1'b0;
    last     = 1'b0;

    if (rx_valid) begin
      if (rx_blk_start) begin
        // Any non-idle state means 1..15 bytes already seen: abandon that block
        cur_st   = classify_blk(rx_sync_hdr, rx_data);
        take     = 1'b1;
        bstart_d = 1'b1;
        eh_d     = hdr_invalid(rx_sync_hdr);
        ea_d     = (state_q != ST_IDLE);
        state_d  = cur_st;
        cnt_d    = 4'd1;
      end else if (state_q != ST_IDLE) begin
        take = 1'b1;
        if (cnt_q == 4'(BLK_BYTES - 1)) begin
          last    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end

    if (take) begin
      vld_d = 1'b1;
      os_d  = (cur_st != ST_DATA);
      case (cur_st)
        ST_DATA: begin
          data_d = rx_data ^ key;
          lfsr_d = lfsr_adv;
        end
        ST_OS: begin
          data_d = rx_data;
          lfsr_d = lfsr_adv;
        end
        ST_SKP: begin
          data_d = rx_data;
        end
        ST_EIE: begin
          data_d = rx_data;
          lfsr_d = last ? SEED : lfsr_adv;
        end
        default: begin
          data_d = rx_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1G) begin
    if (rst_1G) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      lfsr_q   <= SEED;
      data_q   <= 8'h00;
      vld_q    <= 1'b0;
      bstart_q <= 1'b0;
      os_q     <= 1'b0;
      eh_q     <= 1'b0;
      ea_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      bstart_q <= bstart_d;
      os_q     <= os_d;
      eh_q     <= eh_d;
      ea_q     <= ea_d;
    end
  end

  assign dsc_data      = data_q;
  assign dsc_valid     = vld_q;
  assign dsc_blk_start = bstart_q;
  assign dsc_os        = os_q;
  assign err_hdr       = eh_q;
  assign err_align     = ea_q;

endmodule
